// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the instruction/data memory arbiter.
package mem_arb_pkg;

   // Owner of an in-flight RAM read, used to route the returned word.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

   // D_PRIO lets the memory stage win ties; I_FORCE guarantees fetch progress.
   typedef enum logic {
      D_PRIO  = 1'b0,
      I_FORCE = 1'b1
   } arb_state_t;

   localparam int DEF_ADDR_W       = 32;
   localparam int DEF_MEM_LAT      = 1;
   localparam int DEF_MAX_D_STREAK = 4;

   // Byte write enables presented to the RAM: only stores write.
   function automatic logic [3:0] store_we(input logic is_store, input logic [3:0] be);
      return is_store ? be : 4'b0000;
   endfunction

endpackage

// File: rtl/resp_tag_pipe.sv
// Delay line carrying the owner of each RAM access so the read word returning
// DEPTH cycles later can be steered to the side that asked for it.
module resp_tag_pipe
   import mem_arb_pkg::*;
#(
   parameter int DEPTH = DEF_MEM_LAT
) (
   input  logic   clk,
   input  logic   clear,
   input  owner_t tag_in,
   output owner_t tag_out
);

   owner_t stage [DEPTH];

   // Shift one tag per cycle; clear drops every in-flight read.
   always_ff @(posedge clk) begin
      if (clear) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage[i] <= OWN_NONE;
         end
      end else begin
         stage[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port pipelined RAM between fetch (I) and memory stage (D).
// At most one grant per cycle; the winner drives the RAM combinationally and its
// read response is routed back MEM_LAT cycles later via the owner tag pipe.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int MEM_LAT      = DEF_MEM_LAT,
   parameter int MAX_D_STREAK = DEF_MAX_D_STREAK
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              I_Req,
   input  logic [ADDR_W-1:0] I_Addr,
   output logic              I_Gnt,
   output logic              I_RValid,
   output logic [31:0]       I_RData,
   input  logic              D_Req,
   input  logic              D_We,
   input  logic [3:0]        D_Be,
   input  logic [ADDR_W-1:0] D_Addr,
   input  logic [31:0]       D_WData,
   output logic              D_Gnt,
   output logic              D_RValid,
   output logic [31:0]       D_RData,
   output logic              Stall_F,
   output logic              Stall_M,
   output logic              Mem_En,
   output logic [3:0]        Mem_We,
   output logic [ADDR_W-1:0] Mem_Addr,
   output logic [31:0]       Mem_WData,
   input  logic [31:0]       Mem_RData
);

   localparam int               CNT_W      = $clog2(MAX_D_STREAK + 1);
   localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_D_STREAK);

   arb_state_t       state_q, state_d;
   logic [CNT_W-1:0] streak_q, streak_d;
   logic             i_win, d_win;
   owner_t           tag_in, tag_out;

   // Pick the winner: a sole requester always wins, ties follow the FSM; nothing while in reset.
   always_comb begin
      i_win = 1'b0;
      d_win = 1'b0;
      if (!RST) begin
         if (I_Req && D_Req) begin
            if (state_q == I_FORCE) begin
               i_win = 1'b1;
            end else begin
               d_win = 1'b1;
            end
         end else begin
            i_win = I_Req;
            d_win = D_Req;
         end
      end
   end

   // Count D wins that starve a waiting fetch and force I once the limit is hit.
   always_comb begin
      streak_d = streak_q;
      state_d  = state_q;
      if (i_win || !I_Req) begin
         streak_d = '0;
      end else if (d_win && (streak_q != STREAK_MAX)) begin
         streak_d = streak_q + 1'b1;
      end
      case (state_q)
         D_PRIO: begin
            if (streak_d == STREAK_MAX) begin
               state_d = I_FORCE;
            end
         end
         I_FORCE: begin
            if (i_win) begin
               state_d = D_PRIO;
            end
         end
         default: state_d = D_PRIO;
      endcase
   end

   // Arbitration state register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= D_PRIO;
         streak_q <= '0;
      end else begin
         state_q  <= state_d;
         streak_q <= streak_d;
      end
   end

   // Route the winner onto the RAM port and tag the access for response routing.
   always_comb begin
      Mem_En    = i_win | d_win;
      Mem_We    = 4'b0000;
      Mem_Addr  = '0;
      Mem_WData = '0;
      tag_in    = OWN_NONE;
      if (d_win) begin
         Mem_Addr  = D_Addr;
         Mem_We    = store_we(D_We, D_Be);
         Mem_WData = D_WData;
         tag_in    = D_We ? OWN_NONE : OWN_D;
      end else if (i_win) begin
         Mem_Addr = I_Addr;
         tag_in   = OWN_I;
      end
   end

   resp_tag_pipe #(
      .DEPTH(MEM_LAT)
   ) u_tag_pipe (
      .clk    (CLK),
      .clear  (RST),
      .tag_in (tag_in),
      .tag_out(tag_out)
   );

   assign I_Gnt    = i_win;
   assign D_Gnt    = d_win;
   assign Stall_F  = I_Req & ~i_win & ~RST;
   assign Stall_M  = D_Req & ~d_win & ~RST;
   assign I_RValid = ~RST & (tag_out == OWN_I);
   assign D_RValid = ~RST & (tag_out == OWN_D);
   assign I_RData  = Mem_RData;
   assign D_RData  = Mem_RData;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT=1 and 3) share one stimulus stream,
// each backed by its own pipelined RAM model, checked every cycle against a
// queue-based reference model plus literal expectations per directed scenario.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int MAXS = 4;

   typedef struct {
      logic        side_d;
      logic [31:0] data;
      int          gcyc;
   } resp_t;

   logic        CLK = 1'b0;
   logic        RST;
   logic        I_Req, D_Req, D_We;
   logic [31:0] I_Addr, D_Addr, D_WData;
   logic [3:0]  D_Be;

   logic [1:0]  i_gnt, d_gnt, i_rvalid, d_rvalid, stall_f, stall_m, mem_en;
   logic [3:0]  mem_we    [2];
   logic [31:0] mem_addr  [2];
   logic [31:0] mem_wdata [2];
   logic [31:0] mem_rdata [2];
   logic [31:0] i_rdata   [2];
   logic [31:0] d_rdata   [2];

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          streak = 0;
   bit          owed = 1'b0;
   int          head [2];
   resp_t       exp_q [$];
   logic [31:0] shadow [64];
   logic [31:0] obs_i0 [$], obs_i1 [$], obs_d0 [$], obs_d1 [$];
   logic [31:0] want [$];
   logic [9:0]  pat_d0, pat_d1, pat_i0;

   function automatic logic [31:0] init_word(input int i);
      return 32'hC0DE_0000 + 32'(i);
   endfunction

   always #5 CLK = ~CLK;

   mem_arbiter #(.ADDR_W(32), .MEM_LAT(1), .MAX_D_STREAK(MAXS)) dut_l1 (
      .CLK(CLK), .RST(RST),
      .I_Req(I_Req), .I_Addr(I_Addr), .I_Gnt(i_gnt[0]), .I_RValid(i_rvalid[0]), .I_RData(i_rdata[0]),
      .D_Req(D_Req), .D_We(D_We), .D_Be(D_Be), .D_Addr(D_Addr), .D_WData(D_WData),
      .D_Gnt(d_gnt[0]), .D_RValid(d_rvalid[0]), .D_RData(d_rdata[0]),
      .Stall_F(stall_f[0]), .Stall_M(stall_m[0]),
      .Mem_En(mem_en[0]), .Mem_We(mem_we[0]), .Mem_Addr(mem_addr[0]),
      .Mem_WData(mem_wdata[0]), .Mem_RData(mem_rdata[0])
   );

   mem_arbiter #(.ADDR_W(32), .MEM_LAT(3), .MAX_D_STREAK(MAXS)) dut_l3 (
      .CLK(CLK), .RST(RST),
      .I_Req(I_Req), .I_Addr(I_Addr), .I_Gnt(i_gnt[1]), .I_RValid(i_rvalid[1]), .I_RData(i_rdata[1]),
      .D_Req(D_Req), .D_We(D_We), .D_Be(D_Be), .D_Addr(D_Addr), .D_WData(D_WData),
      .D_Gnt(d_gnt[1]), .D_RValid(d_rvalid[1]), .D_RData(d_rdata[1]),
      .Stall_F(stall_f[1]), .Stall_M(stall_m[1]),
      .Mem_En(mem_en[1]), .Mem_We(mem_we[1]), .Mem_Addr(mem_addr[1]),
      .Mem_WData(mem_wdata[1]), .Mem_RData(mem_rdata[1])
   );

   // Pipelined RAM behind each instance: read data appears LAT cycles after the access.
   for (genvar k = 0; k < 2; k++) begin : g_ram
      localparam int LAT = (k == 0) ? 1 : 3;
      logic [31:0] mem     [64];
      logic [31:0] rd_pipe [LAT];

      initial begin
         for (int i = 0; i < 64; i++) mem[i] = init_word(i);
         for (int s = 0; s < LAT; s++) rd_pipe[s] = 32'h0;
      end

      // RAM access and read-latency pipeline.
      always @(posedge CLK) begin
         rd_pipe[0] <= 32'hDEAD_BEEF;
         if (mem_en[k]) begin
            if (mem_we[k] == 4'b0000) begin
               rd_pipe[0] <= mem[mem_addr[k][7:2]];
            end else begin
               for (int b = 0; b < 4; b++)
                  if (mem_we[k][b]) mem[mem_addr[k][7:2]][8*b +: 8] <= mem_wdata[k][8*b +: 8];
            end
         end
         for (int s = 1; s < LAT; s++) rd_pipe[s] <= rd_pipe[s-1];
      end

      assign mem_rdata[k] = rd_pipe[LAT-1];
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic checkObs(input string name, input logic [31:0] got [$], input logic [31:0] exp [$]);
      checkOutput({name, " count"}, 32'(got.size()), 32'(exp.size()));
      for (int i = 0; i < got.size() && i < exp.size(); i++)
         checkOutput($sformatf("%s[%0d]", name, i), got[i], exp[i]);
   endtask

   // Count rising edges so grant and response cycles can be compared.
   always @(posedge CLK) cyc <= cyc + 1;

   // Reference model and per-cycle comparison, sampled mid-cycle on the falling edge.
   always @(negedge CLK) begin
      logic        e_ig, e_dg, e_en, e_irv, e_drv;
      logic [3:0]  e_we;
      logic [31:0] e_addr, e_data;
      string       tag;

      e_ig = 1'b0;
      e_dg = 1'b0;
      if (!RST) begin
         if (I_Req && D_Req) begin
            if (owed) e_ig = 1'b1; else e_dg = 1'b1;
         end else if (I_Req) begin
            e_ig = 1'b1;
         end else if (D_Req) begin
            e_dg = 1'b1;
         end
      end
      e_en   = e_ig | e_dg;
      e_we   = (e_dg && D_We) ? D_Be : 4'b0000;
      e_addr = e_dg ? D_Addr : I_Addr;

      for (int k = 0; k < 2; k++) begin
         tag = (k == 0) ? "L1" : "L3";
         checkOutput({"I_Gnt ", tag}, 32'(i_gnt[k]), 32'(e_ig));
         checkOutput({"D_Gnt ", tag}, 32'(d_gnt[k]), 32'(e_dg));
         checkOutput({"Stall_F ", tag}, 32'(stall_f[k]), 32'(I_Req & ~e_ig & ~RST));
         checkOutput({"Stall_M ", tag}, 32'(stall_m[k]), 32'(D_Req & ~e_dg & ~RST));
         checkOutput({"Mem_En ", tag}, 32'(mem_en[k]), 32'(e_en));
         checkOutput({"Mem_We ", tag}, 32'(mem_we[k]), 32'(e_we));
         if (e_en) checkOutput({"Mem_Addr ", tag}, mem_addr[k], e_addr);
         if (e_dg && D_We) checkOutput({"Mem_WData ", tag}, mem_wdata[k], D_WData);

         e_irv  = 1'b0;
         e_drv  = 1'b0;
         e_data = 32'h0;
         if (!RST && head[k] < exp_q.size()) begin
            if (exp_q[head[k]].gcyc + ((k == 0) ? 1 : 3) == cyc) begin
               e_drv  = exp_q[head[k]].side_d;
               e_irv  = ~exp_q[head[k]].side_d;
               e_data = exp_q[head[k]].data;
               head[k]++;
            end
         end
         checkOutput({"I_RValid ", tag}, 32'(i_rvalid[k]), 32'(e_irv));
         checkOutput({"D_RValid ", tag}, 32'(d_rvalid[k]), 32'(e_drv));
         if (e_irv) checkOutput({"I_RData ", tag}, i_rdata[k], e_data);
         if (e_drv) checkOutput({"D_RData ", tag}, d_rdata[k], e_data);
      end

      if (i_rvalid[0]) obs_i0.push_back(i_rdata[0]);
      if (i_rvalid[1]) obs_i1.push_back(i_rdata[1]);
      if (d_rvalid[0]) obs_d0.push_back(d_rdata[0]);
      if (d_rvalid[1]) obs_d1.push_back(d_rdata[1]);

      if (RST) begin
         exp_q.delete();
         head[0] = 0;
         head[1] = 0;
         streak  = 0;
         owed    = 1'b0;
      end else begin
         if (e_dg) begin
            if (D_We) begin
               for (int b = 0; b < 4; b++)
                  if (D_Be[b]) shadow[D_Addr[7:2]][8*b +: 8] = D_WData[8*b +: 8];
            end else begin
               exp_q.push_back('{1'b1, shadow[D_Addr[7:2]], cyc});
            end
         end
         if (e_ig) exp_q.push_back('{1'b0, shadow[I_Addr[7:2]], cyc});
         if (e_ig || !I_Req) begin
            streak = 0;
            if (e_ig) owed = 1'b0;
         end else if (e_dg) begin
            if (streak < MAXS) streak++;
            if (streak == MAXS) owed = 1'b1;
         end
      end
   end

   task automatic applyStimulus(input logic rst, input logic ireq, input logic [31:0] iaddr,
                                input logic dreq, input logic dwe, input logic [3:0] dbe,
                                input logic [31:0] daddr, input logic [31:0] dwdata);
      @(posedge CLK);
      #1;
      RST = rst;  I_Req = ireq; I_Addr = iaddr;
      D_Req = dreq; D_We = dwe; D_Be = dbe; D_Addr = daddr; D_WData = dwdata;
      @(negedge CLK);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   task automatic clearObs();
      obs_i0.delete(); obs_i1.delete(); obs_d0.delete(); obs_d1.delete();
   endtask

   // Bound total runtime so a broken design can never hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: run did not finish, errors so far %0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios.
   initial begin
      for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
      RST = 1'b1; I_Req = 1'b0; I_Addr = 32'h0;
      D_Req = 1'b0; D_We = 1'b0; D_Be = 4'h0; D_Addr = 32'h0; D_WData = 32'h0;
      head[0] = 0; head[1] = 0;

      $display("[TB] scenario 1: requests held through reset");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b1, 32'h20, 1'b1, 1'b0, 4'hF, 32'h24, 32'h0);
         checkOutput("T1 D_Gnt in reset", 32'(d_gnt[0]), 32'd0);
         checkOutput("T1 Stall_F in reset", 32'(stall_f[1]), 32'd0);
         checkOutput("T1 Mem_En in reset", 32'(mem_en[0]), 32'd0);
      end
      applyStimulus(1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 4'hF, 32'h24, 32'h0);
      checkOutput("T1 first D_Gnt L1", 32'(d_gnt[0]), 32'd1);
      checkOutput("T1 first D_Gnt L3", 32'(d_gnt[1]), 32'd1);
      checkOutput("T1 first I_Gnt L1", 32'(i_gnt[0]), 32'd0);
      idle(5);

      $display("[TB] scenario 2: back-to-back fetches");
      clearObs();
      applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      applyStimulus(1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      applyStimulus(1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      idle(5);
      want = {32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002};
      checkObs("T2 fetch L1", obs_i0, want);
      checkObs("T2 fetch L3", obs_i1, want);

      $display("[TB] scenario 3: continuous contention");
      pat_d0 = '0; pat_d1 = '0; pat_i0 = '0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 1'b1, 32'h8, 1'b1, 1'b0, 4'hF, 32'hC, 32'h0);
         pat_d0 = {pat_d0[8:0], d_gnt[0]};
         pat_d1 = {pat_d1[8:0], d_gnt[1]};
         pat_i0 = {pat_i0[8:0], i_gnt[0]};
      end
      checkOutput("T3 D grant pattern L1", 32'(pat_d0), 32'(10'b1111011110));
      checkOutput("T3 D grant pattern L3", 32'(pat_d1), 32'(10'b1111011110));
      checkOutput("T3 I grant pattern L1", 32'(pat_i0), 32'(10'b0000100001));
      idle(5);

      $display("[TB] scenario 4: partial store then load");
      clearObs();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h10, 32'hAABB_CCDD);
      checkOutput("T4 store Mem_We", 32'(mem_we[0]), 32'(4'b0011));
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
      idle(5);
      want = {32'hC0DE_CCDD};
      checkObs("T4 load L1", obs_d0, want);
      checkObs("T4 load L3", obs_d1, want);

      $display("[TB] scenario 5: reset while a load is in flight");
      clearObs();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h14, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      idle(5);
      want.delete();
      checkObs("T5 flushed L1", obs_d0, want);
      checkObs("T5 flushed L3", obs_d1, want);

      $display("[TB] scenario 6: alternating sole requesters");
      clearObs();
      applyStimulus(1'b0, 1'b1, 32'h18, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h1C, 32'h0);
      applyStimulus(1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h24, 32'h0);
      idle(5);
      want = {32'hC0DE_0006, 32'hC0DE_0008};
      checkObs("T6 I side L1", obs_i0, want);
      checkObs("T6 I side L3", obs_i1, want);
      want = {32'hC0DE_0007, 32'hC0DE_0009};
      checkObs("T6 D side L1", obs_d0, want);
      checkObs("T6 D side L3", obs_d1, want);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
